game_flow_ctrl: RTL and testbench

- Top-level game sequencer. Owns the pre-game / play / game-over flow that the character, bubble and rope blocks follow.
- Tracks lives and level, and times the "get ready" and "hit" freezes in video frames.
- Issues a one-cycle levelStart to respawn the character and bubbles.
- Gates object motion through gameActive and freeze.
- Sits between the collision logic and the per-object move blocks; all per-object start/hit inputs are driven from here.

---
 rtl/game_pkg.sv | 26 ++
 rtl/game_flow_ctrl_if.sv | 28 ++
 rtl/game_flow_ctrl_frame_timer.sv | 25 ++
 rtl/game_flow_ctrl.sv | 104 ++++++++++
 tb/tb_game_flow_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game flow sequencer and the blocks that follow it.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READY,
    PLAY,
    HIT_FREEZE,
    LEVEL_DONE,
    GAME_OVER,
    WIN
  } game_st_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int LIVES_INIT_DEF        = 3;
  localparam int LEVELS_DEF            = 4;
  localparam int READY_FRAMES_DEF      = 90;
  localparam int HIT_FREEZE_FRAMES_DEF = 60;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Frame/collision inputs and flow-control outputs shared between the sequencer and its neighbours.
interface game_flow_ctrl_if #(
    parameter int BUB_CNT_W = 4
);
    logic                 startOfFrame;
    logic                 startKey;
    logic                 charHit;
    logic [BUB_CNT_W-1:0] bubblesLeft;

    logic       levelStart;
    logic       gameActive;
    logic       freeze;
    logic [2:0] level;
    logic [1:0] lives;
    logic       gameOver;
    logic       win;

    // master drives the frame/key/collision side; slave is the sequencer itself
    modport master (
        output startOfFrame, startKey, charHit, bubblesLeft,
        input  levelStart, gameActive, freeze, level, lives, gameOver, win
    );

    modport slave (
        input  startOfFrame, startKey, charHit, bubblesLeft,
        output levelStart, gameActive, freeze, level, lives, gameOver, win
    );
endinterface

// File: rtl/game_flow_ctrl_frame_timer.sv
// Frame counter for the freeze phases; done flags the frame pulse that completes the count.
module frame_timer #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clear,
    input  logic             enable,
    input  logic             startOfFrame,
    input  logic [CNT_W-1:0] target,   // last count value, i.e. frames - 1
    output logic             done
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && startOfFrame)
            cnt <= cnt + 1'b1;
    end

    assign done = enable && startOfFrame && (cnt == target);
endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: pre-game, play, hit/level freezes and end screens; tracks lives and level.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT        = LIVES_INIT_DEF,
    parameter int LEVELS            = LEVELS_DEF,
    parameter int READY_FRAMES      = READY_FRAMES_DEF,
    parameter int HIT_FREEZE_FRAMES = HIT_FREEZE_FRAMES_DEF,
    parameter int BUB_CNT_W         = 4
) (
    input  logic            clk,
    input  logic            resetN,
    game_flow_ctrl_if.slave bus
);
    localparam int FRAMES_MAX = max_int(READY_FRAMES, HIT_FREEZE_FRAMES);
    localparam int CNT_W      = (FRAMES_MAX > 1) ? $clog2(FRAMES_MAX) : 1;

    game_st_t   state, state_next;
    logic [1:0] lives_q, lives_next;
    logic [2:0] level_q, level_next;
    logic       key_d, key_rise;
    logic       level_start_q;
    logic       timer_clear, timer_en, timer_done;
    logic [CNT_W-1:0] timer_target;
    logic       bubs_empty;

    assign key_rise   = bus.startKey & ~key_d;
    assign bubs_empty = (bus.bubblesLeft == {BUB_CNT_W{1'b0}});

    assign timer_en     = (state == READY) || (state == HIT_FREEZE);
    assign timer_clear  = (state_next != state);
    assign timer_target = (state == READY) ? CNT_W'(READY_FRAMES - 1)
                                           : CNT_W'(HIT_FREEZE_FRAMES - 1);

    frame_timer #(.CNT_W(CNT_W)) u_timer (
        .clk          (clk),
        .resetN       (resetN),
        .clear        (timer_clear),
        .enable       (timer_en),
        .startOfFrame (bus.startOfFrame),
        .target       (timer_target),
        .done         (timer_done)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        lives_next = lives_q;
        level_next = level_q;
        unique case (state)
            IDLE: if (key_rise) begin
                lives_next = 2'(LIVES_INIT);
                level_next = '0;
                state_next = READY;
            end
            READY: if (timer_done) state_next = PLAY;
            PLAY: begin
                // a hit wins over a simultaneously emptied field
                if (bus.charHit) begin
                    lives_next = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                    state_next = HIT_FREEZE;
                end else if (bubs_empty) begin
                    state_next = LEVEL_DONE;
                end
            end
            HIT_FREEZE: if (timer_done)
                state_next = (lives_q == 2'd0) ? GAME_OVER : READY;
            LEVEL_DONE: begin
                if (level_q == 3'(LEVELS - 1)) begin
                    state_next = WIN;
                end else begin
                    level_next = level_q + 3'd1;
                    state_next = READY;
                end
            end
            GAME_OVER, WIN: if (key_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE;
            lives_q       <= 2'(LIVES_INIT);
            level_q       <= '0;
            key_d         <= 1'b0;
            level_start_q <= 1'b0;
        end else begin
            state         <= state_next;
            lives_q       <= lives_next;
            level_q       <= level_next;
            key_d         <= bus.startKey;
            level_start_q <= (state_next == READY) && (state != READY);
        end
    end

    assign bus.levelStart = level_start_q;
    assign bus.gameActive = (state == PLAY);
    assign bus.freeze     = (state == READY) || (state == HIT_FREEZE);
    assign bus.level      = level_q;
    assign bus.lives      = lives_q;
    assign bus.gameOver   = (state == GAME_OVER);
    assign bus.win        = (state == WIN);
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: per-cycle comparison against a rule-level model plus literal spot checks.
module tb_game_flow_ctrl;
    localparam int READY_N = 90;
    localparam int HIT_N   = 60;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    game_flow_ctrl_if #(.BUB_CNT_W(4)) bus ();

    game_flow_ctrl #(
        .LIVES_INIT        (3),
        .LEVELS            (4),
        .READY_FRAMES      (READY_N),
        .HIT_FREEZE_FRAMES (HIT_N),
        .BUB_CNT_W         (4)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    // Model: where the game is, how many frames of the current freeze remain.
    localparam int PH_IDLE = 0, PH_READY = 1, PH_PLAY = 2, PH_HIT = 3,
                   PH_LDONE = 4, PH_OVER = 5, PH_WIN = 6;
    int m_phase = PH_IDLE;
    int m_left  = 0;
    int m_lives = 3;
    int m_level = 0;
    bit m_ls    = 1'b0;
    bit m_kd    = 1'b0;
    bit m_rise;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_phase = PH_IDLE; m_left = 0; m_lives = 3; m_level = 0;
            m_ls = 1'b0; m_kd = 1'b0;
        end else begin
            m_rise = bus.startKey && !m_kd;
            m_kd   = bus.startKey;
            m_ls   = 1'b0;
            case (m_phase)
                PH_IDLE: if (m_rise) begin
                    m_lives = 3; m_level = 0;
                    m_phase = PH_READY; m_left = READY_N; m_ls = 1'b1;
                end
                PH_READY: if (bus.startOfFrame) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = PH_PLAY;
                end
                PH_PLAY: begin
                    if (bus.charHit) begin
                        if (m_lives > 0) m_lives = m_lives - 1;
                        m_phase = PH_HIT; m_left = HIT_N;
                    end else if (bus.bubblesLeft == 0) begin
                        m_phase = PH_LDONE;
                    end
                end
                PH_HIT: if (bus.startOfFrame) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (m_lives == 0) m_phase = PH_OVER;
                        else begin m_phase = PH_READY; m_left = READY_N; m_ls = 1'b1; end
                    end
                end
                PH_LDONE: begin
                    if (m_level == 3) m_phase = PH_WIN;
                    else begin
                        m_level = m_level + 1;
                        m_phase = PH_READY; m_left = READY_N; m_ls = 1'b1;
                    end
                end
                default: if (m_rise) m_phase = PH_IDLE;
            endcase
        end
    end

    logic [10:0] got_v, exp_v;
    always @(negedge clk) begin
        got_v = {bus.levelStart, bus.gameActive, bus.freeze, bus.level, bus.lives,
                 bus.gameOver, bus.win};
        exp_v = {m_ls, m_phase == PH_PLAY, (m_phase == PH_READY) || (m_phase == PH_HIT),
                 3'(m_level), 2'(m_lives), m_phase == PH_OVER, m_phase == PH_WIN};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t got={ls,act,frz,lvl,lives,ovr,win}=%b expected=%b",
                     $time, got_v, exp_v);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            bus.startOfFrame = 1'b1; cyc(1);
            bus.startOfFrame = 1'b0; cyc(1);
        end
    endtask

    task automatic press();
        bus.startKey = 1'b0; cyc(1);
        bus.startKey = 1'b1; cyc(1);
        bus.startKey = 1'b0;
    endtask

    task automatic clear_level();
        bus.bubblesLeft = 4'd0; cyc(1);
        bus.bubblesLeft = 4'd5; cyc(1);
        frames(READY_N);
    endtask

    task automatic hit_and_recover();
        bus.charHit = 1'b1; cyc(1);
        bus.charHit = 1'b0;
        frames(HIT_N);
        frames(READY_N);
    endtask

    initial begin
        bus.startOfFrame = 1'b0;
        bus.startKey     = 1'b0;
        bus.charHit      = 1'b0;
        bus.bubblesLeft  = 4'd5;

        cyc(2);
        check("rst_lives", bus.lives, 3);
        check("rst_level", bus.level, 0);
        check("rst_flags", {bus.levelStart, bus.gameActive, bus.freeze, bus.gameOver, bus.win}, 0);
        resetN = 1'b1;
        cyc(2);

        // start: READY with one levelStart, then PLAY after 90 frames
        press();
        check("start_ls", bus.levelStart, 1);
        check("start_lives", bus.lives, 3);
        check("start_freeze", bus.freeze, 1);
        cyc(1);
        check("start_ls_once", bus.levelStart, 0);
        frames(READY_N - 1);
        check("ready_89", bus.gameActive, 0);
        frames(1);
        check("ready_90", bus.gameActive, 1);

        // field emptied: one LEVEL_DONE cycle, then level 1
        cyc(3);
        bus.bubblesLeft = 4'd0; cyc(1);
        check("ldone_active", bus.gameActive, 0);
        check("ldone_level", bus.level, 0);
        bus.bubblesLeft = 4'd5; cyc(1);
        check("lvl1_level", bus.level, 1);
        check("lvl1_ls", bus.levelStart, 1);
        frames(READY_N);

        // held hit costs one life only
        bus.charHit = 1'b1; cyc(3);
        bus.charHit = 1'b0;
        check("hit_lives", bus.lives, 2);
        check("hit_freeze", bus.freeze, 1);
        frames(HIT_N - 1);
        bus.startOfFrame = 1'b1; cyc(1);
        bus.startOfFrame = 1'b0;
        check("rehit_ls", bus.levelStart, 1);
        check("rehit_level", bus.level, 1);
        cyc(1);
        frames(READY_N);

        // hit and empty field together count as a hit
        bus.charHit = 1'b1; bus.bubblesLeft = 4'd0; cyc(1);
        bus.charHit = 1'b0; bus.bubblesLeft = 4'd5;
        check("both_freeze", bus.freeze, 1);
        check("both_lives", bus.lives, 1);
        check("both_level", bus.level, 1);
        frames(HIT_N);
        frames(READY_N);

        // async reset in PLAY at level 2
        clear_level();
        check("lvl2_level", bus.level, 2);
        check("lvl2_active", bus.gameActive, 1);
        #2 resetN = 1'b0;
        #1;
        check("arst_level", bus.level, 0);
        check("arst_lives", bus.lives, 3);
        check("arst_active", bus.gameActive, 0);
        @(negedge clk); #2 resetN = 1'b1;
        cyc(3);
        check("arst_no_ls", {bus.levelStart, bus.freeze}, 0);

        // full run to WIN
        press();
        check("g2_ls", bus.levelStart, 1);
        frames(READY_N);
        clear_level();
        clear_level();
        clear_level();
        check("lvl3_level", bus.level, 3);
        bus.bubblesLeft = 4'd0; cyc(2);
        bus.bubblesLeft = 4'd5;
        check("win_flag", bus.win, 1);
        check("win_level", bus.level, 3);
        press();
        check("win_to_idle", bus.win, 0);

        // three hits to GAME_OVER, with the key held across entry
        press();
        frames(READY_N);
        hit_and_recover();
        hit_and_recover();
        bus.charHit = 1'b1; cyc(1);
        bus.charHit = 1'b0;
        check("third_lives", bus.lives, 0);
        frames(HIT_N - 1);
        bus.startKey = 1'b1;
        bus.startOfFrame = 1'b1; cyc(1);
        bus.startOfFrame = 1'b0;
        check("over_flag", bus.gameOver, 1);
        cyc(5);
        check("over_held_key", bus.gameOver, 1);
        bus.startKey = 1'b0; cyc(1);
        press();
        check("over_to_idle", {bus.gameOver, bus.freeze, bus.gameActive}, 0);
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
